// File: rtl/vec_pkg.sv
// Shared parameters and enumerations for the vector execution unit.
// Vectors are 24 lanes of 8 bits, processed 8 lanes per beat over 3 beats.
package vec_pkg;

    localparam int LANES          = 24;
    localparam int LANE_W         = 8;
    localparam int VEC_W          = LANES * LANE_W;
    localparam int BEATS          = 3;
    localparam int LANES_PER_BEAT = 8;
    localparam int BEAT_W         = LANES_PER_BEAT * LANE_W;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_MULLO = 3'b101,
        OP_SHL   = 3'b110,
        OP_PASS  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/vec_lane_alu.sv
// One 8-bit lane of the vector ALU: purely combinational, results wrap modulo 256.
module vec_lane_alu
    import vec_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] y
);

    always_comb begin
        // NOTE: y gets a default before the case so no path can leave it unassigned (no latch).
        y = '0;
        case (op_e'(op))
            OP_ADD:   y = a + b;
            OP_SUB:   y = a - b;
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_MULLO: y = a * b;
            OP_SHL:   y = a << b[2:0];
            OP_PASS:  y = a;
            default:  y = a;
        endcase
    end

endmodule

// File: rtl/vector_exec_unit.sv
// Multi-beat vector execution unit: accepts one operation, computes 8 lanes per
// cycle over 3 beats, then holds the result until the writeback side accepts it.
module vector_exec_unit
    import vec_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             vs_mode,
    input  logic [VEC_W-1:0] r1v,
    input  logic [VEC_W-1:0] r2v,
    input  logic [7:0]       r1e,
    input  logic [3:0]       dest,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VEC_W-1:0] res_vec,
    output logic [3:0]       res_dest,
    output logic             res_we
);

    state_e            state;
    logic [1:0]        beat;
    op_e               op_q;
    logic [VEC_W-1:0]  a_q;
    logic [VEC_W-1:0]  b_q;
    logic [BEAT_W-1:0] a_slice;
    logic [BEAT_W-1:0] b_slice;
    logic [BEAT_W-1:0] y_slice;

    assign in_ready = (state == IDLE);
    assign res_we   = out_valid;

    // The scalar broadcast is resolved at acceptance, so B is stored lane-ready.
    assign a_slice = a_q[int'(beat) * BEAT_W +: BEAT_W];
    assign b_slice = b_q[int'(beat) * BEAT_W +: BEAT_W];

    for (genvar g = 0; g < LANES_PER_BEAT; g++) begin : g_lane
        vec_lane_alu u_lane (
            .op (op_q),
            .a  (a_slice[g * LANE_W +: LANE_W]),
            .b  (b_slice[g * LANE_W +: LANE_W]),
            .y  (y_slice[g * LANE_W +: LANE_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the wide result/operand registers are reset too, because the outputs must read 0 under reset.
            state     <= IDLE;
            beat      <= '0;
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            out_valid <= 1'b0;
            res_vec   <= '0;
            res_dest  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update tied to the same clock edge.
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= op_e'(op);
                        a_q      <= r1v;
                        b_q      <= vs_mode ? {LANES{r1e}} : r2v;
                        res_dest <= dest;
                        beat     <= '0;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    res_vec[int'(beat) * BEAT_W +: BEAT_W] <= y_slice;
                    if (beat == 2'(BEATS - 1)) begin
                        beat      <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        beat <= beat + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_exec_unit.sv
// Scoreboard bench for vector_exec_unit: directed scenarios plus randomized operations
// checked against a lane-by-lane arithmetic reference model.
module tb_vector_exec_unit;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = '0;
    logic         vs_mode = 1'b0;
    logic [191:0] r1v = '0;
    logic [191:0] r2v = '0;
    logic [7:0]   r1e = '0;
    logic [3:0]   dest = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [191:0] res_vec;
    logic [3:0]   res_dest;
    logic         res_we;

    typedef struct {
        logic [191:0] vec;
        logic [3:0]   dest;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cycle = 0;
    int   passed = 0;
    int   total = 0;
    int   last_acc = 0;
    bit   rand_bp = 1'b0;
    bit   ov_prev = 1'b0;

    vector_exec_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .vs_mode   (vs_mode),
        .r1v       (r1v),
        .r2v       (r2v),
        .r1e       (r1e),
        .dest      (dest),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_vec   (res_vec),
        .res_dest  (res_dest),
        .res_we    (res_we)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: each lane handled independently with integer arithmetic, reduced mod 256.
    function automatic logic [191:0] model(input logic [2:0] o, input logic vs, input logic [191:0] a,
                                           input logic [191:0] b, input logic [7:0] e);
        logic [191:0] res;
        res = '0;
        for (int i = 0; i < 24; i++) begin
            int x, y, r;
            x = int'(a[8*i +: 8]);
            y = vs ? int'(e) : int'(b[8*i +: 8]);
            case (o)
                3'd0: r = x + y;
                3'd1: r = x - y + 256;
                3'd2: r = x & y;
                3'd3: r = x | y;
                3'd4: r = x ^ y;
                3'd5: r = x * y;
                3'd6: r = x << (y % 8);
                default: r = x;
            endcase
            res[8*i +: 8] = r[7:0];
        end
        return res;
    endfunction

    function automatic logic [191:0] rand_vec();
        logic [191:0] v;
        for (int i = 0; i < 6; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Present one operation, wait (bounded) for acceptance, then scramble the inputs.
    task automatic issue(input logic [2:0] o, input logic vs, input logic [191:0] a, input logic [191:0] b,
                         input logic [7:0] e, input logic [3:0] d, input logic [191:0] exp_vec);
        int n;
        exp_t x;
        n = 0;
        while (!in_ready && n < 100) begin
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        if (!in_ready) begin
            total++;
            $display("FAIL accept_timeout: in_ready still 0 after %0d cycles", n);
            return;
        end
        op = o; vs_mode = vs; r1v = a; r2v = b; r1e = e; dest = d; in_valid = 1'b1;
        x.vec = exp_vec;
        x.dest = d;
        exp_q.push_back(x);
        acc_q.push_back(cycle + 1);
        last_acc = cycle + 1;
        tick();
        in_valid = 1'b0;
        op = 3'($urandom); vs_mode = 1'($urandom); r1v = rand_vec(); r2v = rand_vec();
        r1e = 8'($urandom); dest = 4'($urandom);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
            out_ready = 1'b1;
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
        end
    endtask

    // Monitor: latency on each out_valid rise, data on each completed handshake.
    always @(negedge clk) begin
        if (rst) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                if (acc_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_valid: out_valid rose with nothing outstanding");
                end else begin
                    int a;
                    a = acc_q.pop_front();
                    check("latency", 192'(cycle - a), 192'(3));
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_result: got %h", res_vec);
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    check("res_vec", res_vec, x.vec);
                    check("res_dest", 192'(res_dest), 192'(x.dest));
                    check("res_we", 192'(res_we), 192'(1));
                end
            end
            ov_prev = out_valid;
        end
    end

    initial begin
        logic [191:0] a, b, v, snap;
        logic [3:0]   snap_d;
        bit           ok_stable, ok_ready, ov_seen;
        int           n;

        // Reset state
        tick();
        check("rst_out_valid", 192'(out_valid), 192'(0));
        check("rst_res_we", 192'(res_we), 192'(0));
        check("rst_res_vec", res_vec, '0);
        check("rst_res_dest", 192'(res_dest), 192'(0));
        tick();
        rst = 1'b0;
        #1;
        check("ready_after_rst", 192'(in_ready), 192'(1));
        tick();

        // ADD wrap, vector-vector
        issue(3'd0, 1'b0, {24{8'hF0}}, {24{8'h20}}, 8'h00, 4'd5, {24{8'h10}});
        wait_drain();

        // SUB scalar-vector, A lane i = i, r2v ignored
        for (int i = 0; i < 24; i++) begin
            a[8*i +: 8] = 8'(i);
            v[8*i +: 8] = 8'(i - 1);
        end
        issue(3'd1, 1'b1, a, {24{8'hAA}}, 8'h01, 4'd9, v);
        wait_drain();

        // MULLO and SHL spot values
        issue(3'd5, 1'b0, {24{8'h13}}, {24{8'h11}}, 8'h00, 4'd1, {24{8'h43}});
        issue(3'd6, 1'b0, {24{8'h81}}, {24{8'h09}}, 8'h00, 4'd2, {24{8'h02}});
        wait_drain();

        // Backpressure: result held, second request ignored until writeback completes
        out_ready = 1'b0;
        a = rand_vec(); b = rand_vec();
        issue(3'd4, 1'b0, a, b, 8'h00, 4'd7, model(3'd4, 1'b0, a, b, 8'h00));
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        check("bp_valid_seen", 192'(out_valid), 192'(1));
        snap = res_vec; snap_d = res_dest;
        a = rand_vec(); b = rand_vec();
        op = 3'd0; vs_mode = 1'b0; r1v = a; r2v = b; r1e = 8'h00; dest = 4'd3; in_valid = 1'b1;
        ok_stable = 1'b1; ok_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (res_vec !== snap || res_dest !== snap_d || out_valid !== 1'b1) ok_stable = 1'b0;
            if (in_ready !== 1'b0) ok_ready = 1'b0;
        end
        check("bp_stable", 192'(ok_stable), 192'(1));
        check("bp_in_ready_low", 192'(ok_ready), 192'(1));
        out_ready = 1'b1;
        tick();
        check("bp_idle_after_ack", 192'(in_ready), 192'(1));
        check("bp_valid_dropped", 192'(out_valid), 192'(0));
        begin
            exp_t x;
            x.vec = model(3'd0, 1'b0, a, b, 8'h00);
            x.dest = 4'd3;
            exp_q.push_back(x);
            acc_q.push_back(cycle + 1);
        end
        tick();
        in_valid = 1'b0;
        wait_drain();

        // Reset during EXEC beat 1 aborts the operation
        a = rand_vec(); b = rand_vec();
        issue(3'd0, 1'b0, a, b, 8'h00, 4'd11, model(3'd0, 1'b0, a, b, 8'h00));
        tick();
        rst = 1'b1;
        #1;
        exp_q.delete();
        acc_q.delete();
        check("abort_out_valid", 192'(out_valid), 192'(0));
        check("abort_res_we", 192'(res_we), 192'(0));
        check("abort_res_vec", res_vec, '0);
        check("abort_res_dest", 192'(res_dest), 192'(0));
        tick(); tick();
        rst = 1'b0;
        #1;
        check("abort_ready_after_rst", 192'(in_ready), 192'(1));
        ov_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) ov_seen = 1'b1;
        end
        check("abort_no_writeback", 192'(ov_seen), 192'(0));

        // Back-to-back with out_ready tied high: accepts every 5 cycles
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            int prev;
            logic [2:0] o;
            logic vs;
            logic [7:0] e;
            prev = last_acc;
            o = 3'($urandom); vs = 1'($urandom); e = 8'($urandom);
            a = rand_vec(); b = rand_vec();
            issue(o, vs, a, b, e, 4'(i), model(o, vs, a, b, e));
            if (i > 0) check("b2b_spacing", 192'(last_acc - prev), 192'(5));
        end
        wait_drain();

        // Randomized operations with random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 150; i++) begin
            logic [2:0] o;
            logic vs;
            logic [7:0] e;
            o = 3'($urandom); vs = 1'($urandom); e = 8'($urandom);
            a = rand_vec(); b = rand_vec();
            issue(o, vs, a, b, e, 4'($urandom), model(o, vs, a, b, e));
        end
        rand_bp = 1'b0;
        wait_drain();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vector_exec_unit.md
VECTOR_EXEC_UNIT -- requirements
Module: vector_exec_unit

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Ports, clock and reset first:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operands and opcode present.
- in_ready  out  1  unit can accept an operation.
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MULLO, 110 SHL, 111 PASS.
- vs_mode  in  1  0 = vector-vector (b from r2v); 1 = scalar-vector (b = r1e broadcast).
- r1v  in  192  source vector A, 24 lanes x 8 bit, lane i = bits [8i+7:8i].
- r2v  in  192  source vector B.
- r1e  in  8  scalar operand.
- dest  in  4  destination register index (A3 of the register file).
- out_valid  out  1  result ready for writeback.
- out_ready  in  1  writeback accepts the result.
- res_vec  out  192  result vector.
- res_dest  out  4  captured dest.
- res_we  out  1  equals out_valid; drives Reg_write with desType = 1.

Function
REQ-003 SHALL have FSM states IDLE, EXEC, DONE; in_ready = 1 only in IDLE.
REQ-004 IDLE: on in_valid && in_ready, SHALL latch op, vs_mode, r1v, r2v, r1e and dest; go to EXEC; beat counter = 0.
REQ-005 EXEC SHALL process 8 lanes per cycle: beat k (0..2) computes lanes 8k..8k+7 into the result register.
REQ-006 Beat counter SHALL wrap 2 -> 0; after beat 2 the FSM SHALL enter DONE.
REQ-007 out_valid SHALL assert exactly 3 cycles after the accepting edge and hold in DONE.
REQ-008 Arithmetic SHALL be per-lane, 8 bit, modulo 256; no carries between lanes.
REQ-009 MULLO SHALL return the low 8 bits of the 16-bit product.
REQ-010 SHL SHALL shift each A lane left by B_lane[2:0] and zero-fill.
REQ-011 PASS SHALL return A unchanged.
REQ-012 vs_mode = 1 SHALL substitute r1e for every B lane; r2v is ignored.
REQ-013 DONE: on out_ready, SHALL go to IDLE the next cycle, and out_valid SHALL drop; without out_ready, res_vec and res_dest SHALL stay stable (backpressure of unbounded duration).
REQ-014 in_valid is ignored outside IDLE; no new op is accepted in the DONE-to-IDLE cycle.
REQ-015 Latched operands SHALL be immune to changes on the input ports after acceptance.

Reset
REQ-016 rst SHALL force IDLE immediately, at any point including mid-EXEC or DONE: beat counter 0, out_valid 0, res_we 0, res_vec 0, res_dest 0; in_ready becomes 1 after rst deasserts.
REQ-017 An operation aborted by reset SHALL produce no writeback.

Structure
REQ-018 Shared package vec_pkg SHALL hold: LANES = 24, LANE_W = 8, VEC_W = 192, BEATS = 3, LANES_PER_BEAT = 8, the op_e enum, and the state_e enum.
REQ-019 Single sub-module vec_lane_alu: one 8-bit lane (op, a, b -> y), instantiated LANES_PER_BEAT times and fed by a beat-indexed slice mux.

Verification
REQ-020 Directed scenarios:
- ADD vector-vector, all A lanes 0xF0, all B lanes 0x20 -> every lane 0x10 (wrap); out_valid at accept+3; res_dest = dest.
- SUB scalar-vector, A lane i = i, r1e = 0x01 -> lane 0 = 0xFF, lane 23 = 0x16; r2v = all 0xAA is ignored.
- MULLO, A = 0x13, B = 0x11 all lanes -> 0x43; SHL A = 0x81, B = 0x09 -> 0x02 (shift by 1).
- Backpressure: out_ready low for 5 cycles -> res_vec stable, in_ready 0, a second in_valid is ignored; out_ready high -> IDLE next cycle, then the second op is accepted.
- Reset asserted in EXEC beat 1 -> out_valid never rises, all outputs 0, in_ready 1 after release.
- Back-to-back ops with out_ready tied high -> accepts spaced every 5 cycles (IDLE, EXEC x3, DONE); results in order.
